// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the round-robin grant arbiter.
// Contents: FSM state encoding and a compile-time ceil(log2) helper
// used to size the pointer and the hold counter.
package rr_grant_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Ceiling log2; log2(0) and log2(1) both return 0.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_pri_select.sv
// Round-robin priority select: lowest set req bit at index >= ptr, else
// lowest set bit overall (wrap). Purely combinational.
// Ports: req/ptr in; win (one-hot or zero) and any (|req) out.
module rr_pri_select #(
    parameter int NUM_REQ = 8,
    parameter int PTR_W   = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic               any
);

    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] masked;

    // Thermometer mask keeping only indices at or above the pointer.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mask[i] = (i >= int'(ptr));
        end
    end

    assign masked = req & mask;

    // x & -x isolates the lowest set bit, so the result is one-hot or zero.
    assign win = (|masked) ? (masked & (~masked + NUM_REQ'(1)))
                           : (req    & (~req    + NUM_REQ'(1)));
    assign any = |req;

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant, hold/lock and bounded tenure.
// Ports: clk, rst (async, active-high), ena gates new grants, req vector in;
// registered gnt (zero or one-hot), gnt_vld (=|gnt), gnt_new (pulse per new grant).
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 8,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = log2(MAX_HOLD) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_vld,
    output logic               gnt_new
);

    localparam int             PTR_W    = (NUM_REQ > 1) ? log2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic               gnt_new_nxt;

    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] win;
    logic               win_any;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   win_ptr;
    logic               owner_req;
    logic               timeout;
    logic               do_arb;

    // Masking the current owner serves both cases: on release its req bit is
    // already low, and on preemption it must be excluded. In IDLE gnt is zero.
    assign cand = req & ~gnt;

    rr_pri_select #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_sel (
        .req (cand),
        .ptr (ptr),
        .win (win),
        .any (win_any)
    );

    assign owner_req = |(req & gnt);
    assign timeout   = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) && ena && win_any;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                win_idx = PTR_W'(i);
            end
        end
        win_ptr = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        gnt_new_nxt  = 1'b0;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        do_arb       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ena && win_any) begin
                    do_arb = 1'b1;
                end
            end
            ST_GRANT: begin
                if (owner_req && !timeout) begin
                    if ((MAX_HOLD != 0) && (hold_cnt != HOLD_MAX)) begin
                        hold_cnt_nxt = hold_cnt + CNT_W'(1);
                    end
                end else if (ena && win_any) begin
                    do_arb = 1'b1;
                end else begin
                    state_nxt    = ST_IDLE;
                    gnt_nxt      = '0;
                    hold_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                gnt_nxt      = '0;
                hold_cnt_nxt = '0;
            end
        endcase

        if (do_arb) begin
            state_nxt    = ST_GRANT;
            gnt_nxt      = win;
            gnt_new_nxt  = 1'b1;
            hold_cnt_nxt = CNT_W'(1);
            ptr_nxt      = win_ptr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            gnt_vld  <= 1'b0;
            gnt_new  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            gnt_vld  <= |gnt_nxt;
            gnt_new  <= gnt_new_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter (NUM_REQ=8, MAX_HOLD=4, plus a
// MAX_HOLD=0 instance). A behavioural model pushes expected outputs to a
// scoreboard queue as stimulus is driven; entries are popped after each edge.
module tb_rr_grant_arbiter;

    localparam int N  = 8;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] req;
    logic [7:0] gnt, gnt0;
    logic       gnt_vld, gnt_new, gnt_vld0, gnt_new0;

    typedef struct packed {
        logic [7:0] gnt;
        logic       vld;
        logic       nw;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] m_gnt;
    int         m_ptr;
    int         m_cnt;

    always #5 clk = ~clk;

    rr_grant_arbiter #(.NUM_REQ(8), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .req     (req),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_new (gnt_new)
    );

    rr_grant_arbiter #(.NUM_REQ(8), .MAX_HOLD(0)) dut0 (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .req     (req),
        .gnt     (gnt0),
        .gnt_vld (gnt_vld0),
        .gnt_new (gnt_new0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gnt = '0;
        m_ptr = 0;
        m_cnt = 0;
        sbq.delete();
    endtask

    // Behavioural next-cycle prediction: linear search from ptr with wrap.
    task automatic model_step(input logic e, input logic [7:0] r, output exp_t x);
        int         own;
        logic       keep;
        logic       found;
        logic [7:0] cand;
        own  = -1;
        keep = 1'b0;
        for (int i = 0; i < N; i++) if (m_gnt[i]) own = i;
        if (own >= 0) begin
            keep = r[own] && !((m_cnt == MH) && e && ((r & ~m_gnt) != 0));
        end
        if (keep) begin
            if (m_cnt < MH) m_cnt++;
            x = '{gnt: m_gnt, vld: 1'b1, nw: 1'b0};
        end else begin
            cand  = r & ~m_gnt;
            found = 1'b0;
            if (e && cand != 0) begin
                for (int j = 0; j < N; j++) begin
                    int idx;
                    idx = (m_ptr + j) % N;
                    if (!found && cand[idx]) begin
                        found = 1'b1;
                        m_gnt = 8'(1 << idx);
                        m_ptr = (idx + 1) % N;
                        m_cnt = 1;
                    end
                end
                x = '{gnt: m_gnt, vld: 1'b1, nw: 1'b1};
            end else begin
                m_gnt = '0;
                m_cnt = 0;
                x = '{gnt: 8'h00, vld: 1'b0, nw: 1'b0};
            end
        end
    endtask

    task automatic step(input logic e, input logic [7:0] r);
        exp_t x;
        @(negedge clk);
        ena = e;
        req = r;
        model_step(e, r, x);
        sbq.push_back(x);
        @(posedge clk);
        #1;
        x = sbq.pop_front();
        check("sb_gnt", 32'(gnt), 32'(x.gnt));
        check("sb_vld", 32'(gnt_vld), 32'(x.vld));
        check("sb_new", 32'(gnt_new), 32'(x.nw));
        check("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
        check("inv_vld_or", 32'(gnt_vld), 32'(|gnt));
        check("inv_new_nz", 32'(gnt_new && (gnt == 8'h00)), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ena = 1'b0;
        req = 8'h00;
        @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_vld", 32'(gnt_vld), 32'd0);
        check("rst_new", 32'(gnt_new), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int new_cnt;
        rst = 1'b1;
        ena = 1'b0;
        req = 8'h00;
        model_reset();
        do_reset();

        // Async reset mid-grant, then idle with no requests.
        step(1'b1, 8'h04);
        check("pre_rst_gnt", 32'(gnt), 32'h04);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'd0);
        check("async_rst_vld", 32'(gnt_vld), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (10) begin
            step(1'b1, 8'h00);
            check("idle_gnt", 32'(gnt), 32'd0);
        end

        // Fairness: all requesting, each owner drops for one cycle.
        do_reset();
        step(1'b1, 8'hFF);
        check("fair_first", 32'(gnt), 32'h01);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'hFF & ~gnt);
            check("fair_gnt", 32'(gnt), 32'(8'h01 << (i % 8)));
            check("fair_new", 32'(gnt_new), 32'd1);
        end

        // Lock: single requester holds for 20 cycles.
        do_reset();
        new_cnt = 0;
        repeat (20) begin
            step(1'b1, 8'h01);
            check("hold_gnt", 32'(gnt), 32'h01);
            if (gnt_new) new_cnt++;
        end
        check("hold_new_once", 32'(new_cnt), 32'd1);

        // Preemption after MAX_HOLD cycles; MAX_HOLD=0 instance never preempts.
        do_reset();
        step(1'b1, 8'h01);
        check("mh0_gnt", 32'(gnt0), 32'h01);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 8'h11);
            check("mh0_gnt", 32'(gnt0), 32'h01);
            check("pre_gnt", 32'(gnt), (i < 4) ? 32'h01 : 32'h10);
        end
        check("pre_new", 32'(gnt_new), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 8'h11);
            check("mh0_gnt", 32'(gnt0), 32'h01);
            check("pre_back", 32'(gnt), (i < 4) ? 32'h10 : 32'h01);
        end
        check("pre_back_new", 32'(gnt_new), 32'd1);

        // Enable gating.
        do_reset();
        repeat (3) begin
            step(1'b0, 8'h0F);
            check("ena_off_gnt", 32'(gnt), 32'd0);
        end
        step(1'b1, 8'h0F);
        check("ena_on_gnt", 32'(gnt), 32'h01);
        repeat (8) begin
            step(1'b0, 8'h03);
            check("ena_hold_gnt", 32'(gnt), 32'h01);
        end
        step(1'b0, 8'h02);
        check("ena_release", 32'(gnt), 32'd0);

        // Pointer wrap with simultaneous release and new requests.
        do_reset();
        step(1'b1, 8'h40);
        check("wrap_setup", 32'(gnt), 32'h40);
        step(1'b1, 8'h81);
        check("wrap_hi", 32'(gnt), 32'h80);
        step(1'b1, 8'h01);
        check("wrap_lo", 32'(gnt), 32'h01);

        // Random stimulus against the model plus invariants.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 9) != 0), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter for NUM_REQ requesters; issues a registered one-hot grant with hold/lock and bounded tenure.
- Sits directly upstream of the one-hot-to-binary converter. gnt feeds that converter, which produces the channel/select index for the downstream mux and DMA.
- Grant is guaranteed all-zero or exactly one-hot, so the downstream converter needs no extra qualification.

Parameters:
- NUM_REQ, 8: number of requesters; must be >= 1.
- MAX_HOLD, 16: maximum grant tenure in cycles while another request is pending; 0 = unlimited.
- CNT_W, log2(MAX_HOLD) + 1: hold-counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ena  input  1  arbitration enable; gates new grants only.
- req  input  NUM_REQ  request vector; bit i high = requester i wants access.
- gnt  output  NUM_REQ  registered grant; all-zero or one-hot.
- gnt_vld  output  1  registered; equals OR of gnt.
- gnt_new  output  1  registered one-cycle pulse on every new grant, including back-to-back handoff.

Behaviour:
Clock and reset:
- One clock domain. rst asynchronous active-high.
- On reset assertion, immediately: gnt=0, gnt_vld=0, gnt_new=0, ptr=0, hold_cnt=0, state=IDLE.
- Reset asserted mid-grant drops the grant immediately.
- Deassertion is synchronous to clk (external synchroniser assumed).

Selection:
- ptr (0..NUM_REQ-1) marks the highest-priority index.
- Winner = first set req bit at index >= ptr, wrapping to 0.
- Implemented as masked/unmasked priority select: use masked result if non-zero, else unmasked.
- After granting index k: ptr <= (k+1) mod NUM_REQ.

State machine (2 states):
- IDLE:
  - If ena && |req: next cycle gnt=onehot(winner), gnt_new=1, hold_cnt=1, go GRANT.
  - Else gnt stays 0.
  - Latency from req to gnt is 1 cycle.
- GRANT (owner k):
  - If req[k]=1 and not timed out: hold gnt, gnt_new=0. hold_cnt increments, saturating at MAX_HOLD.
  - If req[k]=0 (release):
    - ena && other req pending: next cycle gnt=onehot(new winner), gnt_new=1, hold_cnt=1, stay GRANT. No idle gap.
    - Else gnt=0, go IDLE.
  - Timeout condition: MAX_HOLD != 0 && hold_cnt == MAX_HOLD && ena && (req & ~gnt) != 0.
    - Preempt: next cycle grant the round-robin winner among the others (req with bit k masked), gnt_new=1, hold_cnt=1.
  - hold_cnt == MAX_HOLD with no other request pending: keep the grant, counter saturates.
  - ena=0 in GRANT: current owner keeps the grant until release; no preemption. On release go IDLE.

Invariants and boundaries:
- gnt is never multi-hot.
- gnt_vld == |gnt on every cycle.
- gnt_new never asserts in a cycle where gnt == 0.
- Simultaneous release plus new requests: handled as a release with re-arbitration; the released owner is eligible only after all others (ptr already advanced).
- ptr wraps NUM_REQ-1 -> 0.
- NUM_REQ=1: ptr is constant 0, and preemption can never fire.
- req bits are sampled only at the clock edge; glitches between edges are ignored.

Decomposition:
- Shared package/include: log2 function (existing include), state encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
- One sub-module: rr_pri_select.
  - Combinational; inputs req and ptr; output one-hot winner plus any-valid.
  - Uses masked/unmasked double priority encode.
  - Reused for both fresh arbitration and preemption: the caller masks the owner bit.
- Top level holds state, ptr, hold_cnt and the output registers.

Test Plan (NUM_REQ=8, MAX_HOLD=4 unless stated):
- Reset/idle: assert rst mid-grant (gnt=8'h04) -> gnt=0, gnt_vld=0 with no clock edge. After release, req=8'h00 -> gnt stays 0 indefinitely.
- Fairness: req=8'hFF held, each owner drops req for 1 cycle after grant -> grants cycle 01,02,04,...,80,01. One gnt_new per grant; no idle gaps on back-to-back handoff.
- Lock/hold: req=8'h01 only, held 20 cycles -> gnt=8'h01 for the whole interval, gnt_new once, hold_cnt saturates, no drop.
- Preemption: req=8'h01 granted, then req=8'h11 held -> after 4 grant cycles gnt=8'h10 with gnt_new=1. Next preemption returns to 8'h01. With MAX_HOLD=0, gnt stays 8'h01.
- Enable gating: ena=0 with req=8'h0F -> gnt=0. Set ena=1 -> gnt=8'h01 next cycle. Drop ena during grant with req=8'h03 -> owner held past MAX_HOLD, then gnt=0 on release.
- Wrap/simultaneous: ptr=7, req=8'h81 -> gnt=8'h80, then on release gnt=8'h01. Random req stimulus for 10k cycles -> assert gnt is one-hot-or-zero and gnt_vld==|gnt every cycle.
